// File: rtl/logic_reduce_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : logic_reduce_pipe_pkg                                     |
// | Purpose  : Shared definitions for the pipelined bitwise reduction.   |
// |            Holds the OP encodings and the elaboration-time helpers   |
// |            that size the reduction tree.                             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package logic_reduce_pipe_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_NAND = 2'b11
   } op_e;

   // Ceiling log2. The operand count never exceeds 16, so 16 probes is
   // plenty and stays clear of the signed overflow at 1<<31.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 16; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Number of operands present at tree level lvl (level 0 is the input).
   // Each level halves the count, rounding up for an odd leftover.
   function automatic int lvl_cnt(input int n, input int lvl);
      int c;
      c = n;
      for (int i = 0; i < 16; i++) begin
         if (i < lvl) c = (c + 1) / 2;
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/logic_reduce_pipe_reduce_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reduce_stage                                              |
// | Purpose  : One level of the reduction tree. Combines operand pairs   |
// |            (2k, 2k+1) with the operation selected by op_i and        |
// |            registers the result together with op and valid.          |
// |            An odd leftover operand passes through unchanged.         |
// | Ports    : clk_i, rst_i   clock, async active-high reset             |
// |            en_i           global pipeline advance                    |
// |            valid_i/op_i/data_i    NIN operands in                    |
// |            valid_o/op_o/data_o    ceil(NIN/2) operands out           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module reduce_stage
   import logic_reduce_pipe_pkg::*;
#(
   parameter int W   = 8,
   parameter int NIN = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         en_i,
   input  logic                         valid_i,
   input  logic [1:0]                   op_i,
   input  logic [NIN*W-1:0]             data_i,
   output logic                         valid_o,
   output logic [1:0]                   op_o,
   output logic [((NIN+1)/2)*W-1:0]     data_o
);

   localparam int NOUT = (NIN + 1) / 2;

   logic [NOUT*W-1:0] data_d;
   logic [NOUT*W-1:0] data_q;
   logic [1:0]        op_q;
   logic              valid_q;

   for (genvar k = 0; k < NOUT; k++) begin : g_lane
      if (2*k + 1 < NIN) begin : g_pair
         logic [W-1:0] a;
         logic [W-1:0] b;
         assign a = data_i[(2*k)*W +: W];
         assign b = data_i[(2*k+1)*W +: W];
         // NAND travels as AND through the tree; the inversion happens
         // once, after the final level.
         assign data_d[k*W +: W] = (op_i == OP_OR)  ? (a | b) :
                                   (op_i == OP_XOR) ? (a ^ b) :
                                                      (a & b);
      end else begin : g_pass
         assign data_d[k*W +: W] = data_i[(2*k)*W +: W];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         op_q    <= OP_AND;
         data_q  <= '0;
      end else if (en_i) begin
         valid_q <= valid_i;
         op_q    <= op_i;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign op_o    = op_q;
   assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/logic_reduce_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : logic_reduce_pipe                                         |
// | Purpose  : Pipelined bitwise reduction (AND/OR/XOR/NAND) of N        |
// |            W-bit operands through a balanced tree, one register      |
// |            level per tree level, with valid/ready flow control.      |
// | Ports    : CLK, RST          clock, async active-high reset          |
// |            I, OP, I_VALID    operands/op in; I_READY back-pressure   |
// |            O, O_VALID        result out; O_READY from downstream     |
// |            O_CNT             16-bit wrapping count of transfers      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module logic_reduce_pipe
   import logic_reduce_pipe_pkg::*;
#(
   parameter int W = 8,
   parameter int N = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N*W-1:0]   I,
   input  logic [1:0]       OP,
   input  logic             I_VALID,
   output logic             I_READY,
   output logic [W-1:0]     O,
   output logic             O_VALID,
   input  logic             O_READY,
   output logic [15:0]      O_CNT
);

   localparam int LAT = clog2(N);

   logic        en;
   logic [15:0] cnt_d;
   logic [15:0] cnt_q;

   // The whole pipe moves in lock-step: it advances whenever the output
   // register is empty or is being drained this cycle.
   assign en      = O_READY | ~O_VALID;
   assign I_READY = en;

   for (genvar l = 0; l < LAT; l++) begin : g_stage
      localparam int NIN  = lvl_cnt(N, l);
      localparam int NOUT = lvl_cnt(N, l + 1);

      logic [NIN*W-1:0]  data_in;
      logic [1:0]        op_in;
      logic              vld_in;
      logic [NOUT*W-1:0] data_out;
      logic [1:0]        op_out;
      logic              vld_out;

      if (l == 0) begin : g_first
         assign data_in = I;
         assign op_in   = OP;
         assign vld_in  = I_VALID;
      end else begin : g_next
         assign data_in = g_stage[l-1].data_out;
         assign op_in   = g_stage[l-1].op_out;
         assign vld_in  = g_stage[l-1].vld_out;
      end

      reduce_stage #(
         .W   (W),
         .NIN (NIN)
      ) u_stage (
         .clk_i   (CLK),
         .rst_i   (RST),
         .en_i    (en),
         .valid_i (vld_in),
         .op_i    (op_in),
         .data_i  (data_in),
         .valid_o (vld_out),
         .op_o    (op_out),
         .data_o  (data_out)
      );
   end

   // Reset leaves op at AND and data at zero, so O reads zero in reset.
   assign O       = (g_stage[LAT-1].op_out == OP_NAND) ? ~g_stage[LAT-1].data_out
                                                       :  g_stage[LAT-1].data_out;
   assign O_VALID = g_stage[LAT-1].vld_out;

   assign cnt_d = (O_VALID && O_READY) ? cnt_q + 16'd1 : cnt_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign O_CNT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_reduce_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_logic_reduce_pipe                                      |
// | Purpose  : Self-checking bench for logic_reduce_pipe (N=4 and N=3).  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_logic_reduce_pipe;
   import logic_reduce_pipe_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] I = '0;
   logic [1:0]  OP = 2'b00;
   logic        I_VALID = 1'b0;
   logic        I_READY;
   logic [7:0]  O;
   logic        O_VALID;
   logic        O_READY = 1'b1;
   logic [15:0] O_CNT;

   logic [23:0] I3 = '0;
   logic [1:0]  OP3 = 2'b00;
   logic        I3_VALID = 1'b0;
   logic        I3_READY;
   logic [7:0]  O3;
   logic        O3_VALID;
   logic        O3_READY = 1'b1;
   logic [15:0] O3_CNT;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  sb[$];
   logic [7:0]  nxt_exp = '0;
   logic [7:0]  held;
   logic [15:0] cnt0;

   typedef struct {
      logic [31:0] i;
      logic [1:0]  op;
      logic [7:0]  exp;
   } vec_t;
   vec_t tbl[12];

   always #5 CLK = ~CLK;

   logic_reduce_pipe #(.W(8), .N(4)) dut (
      .CLK(CLK), .RST(RST), .I(I), .OP(OP), .I_VALID(I_VALID), .I_READY(I_READY),
      .O(O), .O_VALID(O_VALID), .O_READY(O_READY), .O_CNT(O_CNT)
   );

   logic_reduce_pipe #(.W(8), .N(3)) dut3 (
      .CLK(CLK), .RST(RST), .I(I3), .OP(OP3), .I_VALID(I3_VALID), .I_READY(I3_READY),
      .O(O3), .O_VALID(O3_VALID), .O_READY(O3_READY), .O_CNT(O3_CNT)
   );

   function automatic logic [7:0] model(input logic [31:0] v, input logic [1:0] op);
      logic [7:0] a, o, x;
      a = 8'hFF; o = 8'h00; x = 8'h00;
      for (int k = 0; k < 4; k++) begin
         a = a & v[k*8 +: 8];
         o = o | v[k*8 +: 8];
         x = x ^ v[k*8 +: 8];
      end
      case (op)
         2'b00:   return a;
         2'b01:   return o;
         2'b10:   return x;
         default: return ~a;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called just after a falling edge with inputs already set; scores any
   // output transfer and records any acceptance, then moves to the next
   // falling edge.
   task automatic step();
      #1;
      if (O_VALID && O_READY) begin
         if (sb.size() == 0) check("sb_extra_out", {31'd0, O_VALID}, 32'd0);
         else                check("sb_data", {24'd0, O}, {24'd0, sb.pop_front()});
      end
      if (I_VALID && I_READY) sb.push_back(nxt_exp);
      @(negedge CLK);
   endtask

   task automatic drain();
      I_VALID = 1'b0;
      O_READY = 1'b1;
      for (int k = 0; k < 20 && sb.size() != 0; k++) step();
      check("drain_empty", sb.size(), 0);
      sb.delete();
   endtask

   task automatic drive(input logic [31:0] v, input logic [1:0] op, input logic [7:0] e);
      I = v; OP = op; I_VALID = 1'b1; nxt_exp = e;
      step();
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{32'hFF3CF0FF, 2'b00, 8'h30};
      tbl[1]  = '{32'hFF3CF0FF, 2'b01, 8'hFF};
      tbl[2]  = '{32'hFF3CF0FF, 2'b10, 8'hCC};
      tbl[3]  = '{32'hFF3CF0FF, 2'b11, 8'hCF};
      tbl[4]  = '{32'h01020408, 2'b00, 8'h00};
      tbl[5]  = '{32'h01020408, 2'b01, 8'h0F};
      tbl[6]  = '{32'h01020408, 2'b10, 8'h0F};
      tbl[7]  = '{32'h01020408, 2'b11, 8'hFF};
      tbl[8]  = '{32'hAAAAAAAA, 2'b10, 8'h00};
      tbl[9]  = '{32'hAAAAAAAA, 2'b11, 8'h55};
      tbl[10] = '{32'h12345678, 2'b10, 8'h08};
      tbl[11] = '{32'h12345678, 2'b01, 8'h7E};

      // Reset state, before and after clock edges.
      #1;
      check("rst_ovalid", {31'd0, O_VALID}, 32'd0);
      check("rst_o", {24'd0, O}, 32'd0);
      check("rst_cnt", {16'd0, O_CNT}, 32'd0);
      check("rst_iready", {31'd0, I_READY}, 32'd1);
      @(negedge CLK);
      @(negedge CLK);
      check("rst_ovalid_clk", {31'd0, O_VALID}, 32'd0);

      // First acceptance on the first edge after release; latency 2.
      RST = 1'b0;
      O_READY = 1'b1;
      drive(32'hFF3CF0FF, OP_AND, 8'h30);
      I_VALID = 1'b0;
      #1 check("lat_cycle1_ovalid", {31'd0, O_VALID}, 32'd0);
      step();
      #1 check("lat_cycle2_ovalid", {31'd0, O_VALID}, 32'd1);
      check("lat_cycle2_o", {24'd0, O}, 32'h30);
      step();
      #1 check("cnt_after_one", {16'd0, O_CNT}, 32'd1);

      // N=3: odd leftover passes through level 0.
      I3 = 24'h1FFF0F; OP3 = OP_OR; I3_VALID = 1'b1; O3_READY = 1'b1;
      #1 check("n3_iready", {31'd0, I3_READY}, 32'd1);
      @(negedge CLK);
      I3_VALID = 1'b0;
      #1 check("n3_cycle1_ovalid", {31'd0, O3_VALID}, 32'd0);
      @(negedge CLK);
      #1 check("n3_cycle2_ovalid", {31'd0, O3_VALID}, 32'd1);
      check("n3_o", {24'd0, O3}, 32'hFF);
      @(negedge CLK);
      #1 check("n3_cnt", {16'd0, O3_CNT}, 32'd1);

      // Back-to-back AND/OR/XOR/NAND, then the rest of the table.
      cnt0 = O_CNT;
      for (int v = 0; v < 4; v++) drive(tbl[v].i, tbl[v].op, tbl[v].exp);
      drain();
      check("cnt_b2b", {16'd0, O_CNT}, {16'd0, cnt0 + 16'd4});
      for (int v = 4; v < 12; v++) drive(tbl[v].i, tbl[v].op, tbl[v].exp);
      drain();

      // Stall with the pipe full: output and back-pressure hold.
      cnt0 = O_CNT;
      drive(tbl[4].i, tbl[4].op, tbl[4].exp);
      drive(tbl[5].i, tbl[5].op, tbl[5].exp);
      O_READY = 1'b0;
      I = tbl[6].i; OP = tbl[6].op; I_VALID = 1'b1; nxt_exp = tbl[6].exp;
      held = sb[0];
      for (int s = 0; s < 5; s++) begin
         #1;
         check("stall_iready", {31'd0, I_READY}, 32'd0);
         check("stall_ovalid", {31'd0, O_VALID}, 32'd1);
         check("stall_o", {24'd0, O}, {24'd0, held});
         @(negedge CLK);
      end
      O_READY = 1'b1;
      step();
      drive(tbl[7].i, tbl[7].op, tbl[7].exp);
      drain();
      check("stall_cnt", {16'd0, O_CNT}, {16'd0, cnt0 + 16'd4});

      // Random valid/ready traffic against the reference model.
      for (int r = 0; r < 400; r++) begin
         I = $urandom;
         OP = 2'($urandom_range(0, 3));
         I_VALID = ($urandom_range(0, 3) != 0);
         O_READY = ($urandom_range(0, 2) != 0);
         nxt_exp = model(I, OP);
         step();
      end
      drain();

      // Reset with two beats in flight.
      drive(tbl[0].i, tbl[0].op, tbl[0].exp);
      drive(tbl[1].i, tbl[1].op, tbl[1].exp);
      I_VALID = 1'b0;
      O_READY = 1'b0;
      #1 check("pre_rst_ovalid", {31'd0, O_VALID}, 32'd1);
      RST = 1'b1;
      #1;
      check("async_rst_ovalid", {31'd0, O_VALID}, 32'd0);
      check("async_rst_cnt", {16'd0, O_CNT}, 32'd0);
      check("async_rst_o", {24'd0, O}, 32'd0);
      check("rst_iready_stalled", {31'd0, I_READY}, 32'd1);
      sb.delete();
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      O_READY = 1'b1;
      for (int s = 0; s < 5; s++) begin
         #1 check("no_stale_beat", {31'd0, O_VALID}, 32'd0);
         @(negedge CLK);
      end
      check("post_rst_cnt", {16'd0, O_CNT}, 32'd0);

      // Counter wrap: 65535 transfers, then one more.
      for (int b = 0; b < 65535; b++) begin
         I = $urandom;
         OP = 2'($urandom_range(0, 3));
         I_VALID = 1'b1;
         nxt_exp = model(I, OP);
         step();
      end
      drain();
      check("cnt_ffff", {16'd0, O_CNT}, 32'h0000FFFF);
      drive(tbl[9].i, tbl[9].op, tbl[9].exp);
      drain();
      check("cnt_wrap", {16'd0, O_CNT}, 32'h00000000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
